mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter MUL_LAT, default 2: fixed multiplier latency in cycles, mul_a/mul_b sample edge to mul_z valid.
REQ-002 Parameter FIFO_DEPTH, default 4: result FIFO entries per requester, power of two, >= 2.
REQ-003 Parameter W, default 32: operand width; product width 2*W.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) presents an operand pair.
REQ-007 reqN_ready  out  1  operand pair accepted this cycle.
REQ-008 reqN_a, reqN_b  in  W  signed two's-complement operands.
REQ-009 rspN_valid  out  1  FIFO head product available to requester N.
REQ-010 rspN_ready  in  1  requester N consumes the head product.
REQ-011 rspN_z  out  2W  signed product at the FIFO head.
REQ-012 mul_a, mul_b  out  W  operands driven to the shared signed multiplier.
REQ-013 mul_z  in  2W  multiplier product, MUL_LAT cycles after the operands.
REQ-014 idle  out  1  high when nothing is in flight and both FIFOs are empty.

Function
REQ-015 Arbitration SHALL be round-robin with a 1-bit priority pointer: with both eligible, the pointer index is granted; the pointer then moves to the other index.
REQ-016 Requester N SHALL be eligible when reqN_valid=1 and inflightN + countN < FIFO_DEPTH, using registered counts only.
REQ-017 At most one grant per cycle; reqN_ready SHALL be combinational and high only for the granted requester.
REQ-018 On a grant, mul_a/mul_b SHALL carry the granted operands combinationally that cycle; with no grant they SHALL be 0.
REQ-019 A tag pipeline of MUL_LAT stages {valid, id} SHALL shift every cycle; stage 0 loads {grant, granted index}.
REQ-020 When the last tag stage is valid, mul_z SHALL be written into FIFO[id] that cycle; rspN_valid rises the next cycle. Issue-to-rsp_valid latency = MUL_LAT+1 cycles.
REQ-021 inflightN SHALL increment on issue and decrement on FIFO write; simultaneous issue and write for the same N leaves it unchanged.
REQ-022 A FIFO pop (rspN_valid & rspN_ready) SHALL NOT free a credit in the same cycle; the credit is usable the following cycle.
REQ-023 A FIFO write SHALL never hit a full FIFO; this holds by construction from REQ-016.
REQ-024 Simultaneous push and pop on a full or empty FIFO SHALL be legal; the count changes by push minus pop, and pop on empty is masked.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; results per requester are returned in issue order.
REQ-026 Back-to-back issue every cycle SHALL be supported; the multiplier is fully pipelined.

Reset
REQ-027 Reset SHALL clear tag valids, inflight counters, FIFO pointers and counts, and set the priority pointer to 0.
REQ-028 During and after reset: reqN_ready=0 while reset is high, rspN_valid=0, mul_a=mul_b=0, idle=1.
REQ-029 Products of operations in flight when reset asserts SHALL be discarded and never appear on rspN.

Structure
REQ-030 Package mult_arb_pkg SHALL hold the MUL_LAT/FIFO_DEPTH/W defaults and the tag typedef {valid, id}.
REQ-031 Sub-module mult_rsp_fifo (synchronous FIFO, count output) SHALL be instantiated once per requester.
REQ-032 The multiplier SHALL be external to this block and connected only through the mul_* ports.

Verification
REQ-033 Single op: req0 a=-3, b=7 at cycle 0 -> req0_ready=1 at cycle 0; rsp0_valid at cycle 3; rsp0_z=-21.
REQ-034 Contention: req0 and req1 valid continuously, pointer=0 -> grants alternate 0,1,0,1 and each response stream stays in issue order.
REQ-035 Backpressure: rsp1_ready=0 with req1 always valid -> exactly 4 grants to req1, then req1_ready=0; one pop -> one new grant on the cycle after the pop.
REQ-036 Extremes: a=0x80000000, b=0x80000000 -> z=0x4000000000000000; a=-1, b=1 -> z=all ones.
REQ-037 Reset mid-flight: issue 2 ops, assert reset 1 cycle later -> no rsp_valid afterwards, idle=1, counts are 0.
REQ-038 Simultaneous push and pop on a full FIFO with rsp_ready held high -> count stays at 4 and no data is lost or duplicated.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared defaults and types for the two-requester multiplier arbiter.
package mult_arb_pkg;

    localparam int MUL_LAT_DEF    = 2;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int W_DEF          = 32;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/mult_rsp_fifo.sv
// Per-requester result FIFO; pop on empty is ignored, push+pop may coincide.
module mult_rsp_fifo
    import mult_arb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int DW    = 2 * W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_en;

    assign valid    = (count != '0);
    assign pop_en   = pop && valid;
    assign pop_data = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one external pipelined signed multiplier between
// two requesters, with credit-checked per-requester result FIFOs.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int MUL_LAT    = MUL_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int W          = W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [2*W-1:0]   rsp0_z,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [2*W-1:0]   rsp1_z,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_z,
    output logic             idle
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0] inflight0;
    logic [CW-1:0] inflight1;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;
    logic          elig0;
    logic          elig1;
    logic          ptr;
    logic          grant;
    logic          gnt_id;
    logic          wr0;
    logic          wr1;
    tag_t          tags [MUL_LAT];

    // Credits use registered counts only, so a pop frees a slot next cycle.
    assign elig0 = req0_valid &&
        (({1'b0, inflight0} + {1'b0, count0}) < (CW+1)'(FIFO_DEPTH));
    assign elig1 = req1_valid &&
        (({1'b0, inflight1} + {1'b0, count1}) < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        grant  = 1'b0;
        gnt_id = 1'b0;
        if (!reset) begin
            if (elig0 && elig1) begin
                grant  = 1'b1;
                gnt_id = ptr;
            end else if (elig0) begin
                grant  = 1'b1;
                gnt_id = 1'b0;
            end else if (elig1) begin
                grant  = 1'b1;
                gnt_id = 1'b1;
            end
        end
    end

    assign req0_ready = grant && !gnt_id;
    assign req1_ready = grant && gnt_id;
    assign mul_a = !grant ? '0 : (gnt_id ? req1_a : req0_a);
    assign mul_b = !grant ? '0 : (gnt_id ? req1_b : req0_b);

    assign wr0 = tags[MUL_LAT-1].valid && !tags[MUL_LAT-1].id;
    assign wr1 = tags[MUL_LAT-1].valid && tags[MUL_LAT-1].id;

    // Tags track the multiplier pipeline; clearing them drops stale products.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++)
                tags[i] <= '0;
            ptr       <= 1'b0;
            inflight0 <= '0;
            inflight1 <= '0;
        end else begin
            tags[0] <= {grant, gnt_id};
            for (int i = 1; i < MUL_LAT; i++)
                tags[i] <= tags[i-1];
            if (grant)
                ptr <= ~gnt_id;
            inflight0 <= inflight0 + CW'(req0_ready) - CW'(wr0);
            inflight1 <= inflight1 + CW'(req1_ready) - CW'(wr1);
        end
    end

    mult_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (2*W)
    ) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (wr0),
        .push_data (mul_z),
        .pop       (rsp0_ready),
        .pop_data  (rsp0_z),
        .valid     (rsp0_valid),
        .count     (count0)
    );

    mult_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (2*W)
    ) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (wr1),
        .push_data (mul_z),
        .pop       (rsp1_ready),
        .pop_data  (rsp1_z),
        .valid     (rsp1_valid),
        .count     (count1)
    );

    assign idle = (inflight0 == '0) && (inflight1 == '0) &&
                  (count0 == '0) && (count1 == '0);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural pipelined multiplier.
module tb_mult_arbiter;

    localparam int W     = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [2*W-1:0] rsp0_z, rsp1_z;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_z;
    logic           idle;

    logic           f_push, f_pop, f_valid;
    logic [7:0]     f_din, f_dout;
    logic [2:0]     f_count;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    mult_arbiter #(
        .MUL_LAT    (LAT),
        .FIFO_DEPTH (DEPTH),
        .W          (W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_z     (rsp0_z),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_z     (rsp1_z),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_z      (mul_z),
        .idle       (idle)
    );

    mult_rsp_fifo #(
        .DEPTH (4),
        .DW    (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (f_push),
        .push_data (f_din),
        .pop       (f_pop),
        .pop_data  (f_dout),
        .valid     (f_valid),
        .count     (f_count)
    );

    // External multiplier: LAT register stages, sign-extended operands.
    logic [2*W-1:0] mpipe [LAT];
    always_ff @(posedge clk) begin
        mpipe[0] <= {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
        for (int i = 1; i < LAT; i++)
            mpipe[i] <= mpipe[i-1];
    end
    assign mul_z = mpipe[LAT-1];

    typedef struct {
        bit          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0;
        req0_b = '0;
        req1_a = '0;
        req1_b = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit got;
        int lat;
        got = 1'b0;
        lat = 0;
        if (v.id) begin
            req1_valid = 1'b1;
            req1_a = v.a;
            req1_b = v.b;
        end else begin
            req0_valid = 1'b1;
            req0_a = v.a;
            req0_b = v.b;
        end
        #1;
        chk($sformatf("vec%0d_ready", idx),
            64'(v.id ? req1_ready : req0_ready), 64'(1));
        chk($sformatf("vec%0d_mul_a", idx), 64'(mul_a), 64'(v.a));
        for (int c = 1; c <= 8 && !got; c++) begin
            step();
            idle_inputs();
            #1;
            if (v.id ? rsp1_valid : rsp0_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'(3));
        chk($sformatf("vec%0d_z", idx), v.id ? rsp1_z : rsp0_z, v.z);
        step();
    endtask

    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    initial begin
        int k0, k1, g, grants;
        logic signed [63:0] p;

        vt[0] = '{0, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB};
        vt[1] = '{0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vt[2] = '{1, 32'hFFFF_FFFF, 32'd1,         64'hFFFF_FFFF_FFFF_FFFF};
        vt[3] = '{1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vt[4] = '{0, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        vt[5] = '{1, 32'd0,         32'hFFFF_FFFF, 64'd0};
        vt[6] = '{0, 32'd12345,     32'd1000,      64'd12345000};
        vt[7] = '{1, 32'hFFFF_FFFA, 32'hFFFF_FFF7, 64'd54};

        f_push = 1'b0;
        f_pop  = 1'b0;
        f_din  = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        idle_inputs();

        // Reset state, with requests asserted to show ready is held low.
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = 32'd5;
        req0_b = 32'd6;
        step();
        step();
        #1;
        chk("rst_req0_ready", 64'(req0_ready), 64'(0));
        chk("rst_req1_ready", 64'(req1_ready), 64'(0));
        chk("rst_rsp0_valid", 64'(rsp0_valid), 64'(0));
        chk("rst_rsp1_valid", 64'(rsp1_valid), 64'(0));
        chk("rst_mul_a", 64'(mul_a), 64'(0));
        chk("rst_mul_b", 64'(mul_b), 64'(0));
        chk("rst_idle", 64'(idle), 64'(1));
        idle_inputs();
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++)
            run_vec(i, vt[i]);
        #1;
        chk("vec_idle_after", 64'(idle), 64'(1));

        // Contention: both valid for 8 cycles, pointer starts at 0.
        do_reset();
        k0 = 0;
        k1 = 0;
        g  = 0;
        for (int c = 0; c < 20; c++) begin
            req0_valid = (c < 8);
            req1_valid = (c < 8);
            req0_a = 32'(10 + k0);
            req0_b = 32'd2;
            req1_a = 32'(-(5 + k1));
            req1_b = 32'd3;
            #1;
            if (c < 8) begin
                chk($sformatf("cont_grant_c%0d", c),
                    64'({req1_ready, req0_ready}), 64'(g ? 2 : 1));
                g ^= 1;
            end
            if (req0_ready) begin
                p = 64'((10 + k0) * 2);
                q0.push_back(p);
                k0++;
            end
            if (req1_ready) begin
                p = -(5 + k1) * 3;
                q1.push_back(p);
                k1++;
            end
            if (rsp0_valid) begin
                if (q0.size() == 0)
                    chk("cont_rsp0_spurious", 64'(1), 64'(0));
                else
                    chk("cont_rsp0_z", rsp0_z, q0.pop_front());
            end
            if (rsp1_valid) begin
                if (q1.size() == 0)
                    chk("cont_rsp1_spurious", 64'(1), 64'(0));
                else
                    chk("cont_rsp1_z", rsp1_z, q1.pop_front());
            end
            step();
        end
        chk("cont_q0_left", 64'(q0.size()), 64'(0));
        chk("cont_q1_left", 64'(q1.size()), 64'(0));

        // Backpressure on requester 1: four credits, then stall.
        do_reset();
        rsp1_ready = 1'b0;
        grants = 0;
        k1 = 0;
        q1.delete();
        for (int c = 0; c < 10; c++) begin
            req1_valid = 1'b1;
            req1_a = 32'(100 + k1);
            req1_b = 32'd1;
            #1;
            if (req1_ready) begin
                grants++;
                q1.push_back(64'(100 + k1));
                k1++;
            end
            step();
        end
        chk("bp_grants", 64'(grants), 64'(4));
        rsp1_ready = 1'b1;
        #1;
        chk("bp_ready_on_pop", 64'(req1_ready), 64'(0));
        chk("bp_rsp1_valid", 64'(rsp1_valid), 64'(1));
        chk("bp_pop_z", rsp1_z, q1.pop_front());
        step();
        rsp1_ready = 1'b0;
        req1_a = 32'(100 + k1);
        #1;
        chk("bp_ready_after_pop", 64'(req1_ready), 64'(1));
        if (req1_ready) begin
            q1.push_back(64'(100 + k1));
            k1++;
        end
        step();
        req1_a = 32'(100 + k1);
        #1;
        chk("bp_ready_refull", 64'(req1_ready), 64'(0));
        req1_valid = 1'b0;
        rsp1_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp1_valid) begin
                if (q1.size() == 0)
                    chk("bp_rsp1_spurious", 64'(1), 64'(0));
                else
                    chk("bp_drain_z", rsp1_z, q1.pop_front());
            end
            step();
        end
        chk("bp_q1_left", 64'(q1.size()), 64'(0));

        // Reset while two ops are in flight.
        do_reset();
        req0_valid = 1'b1;
        req0_a = 32'd3;
        req0_b = 32'd4;
        step();
        req0_a = 32'd5;
        step();
        req0_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("mid_rsp0_valid_c%0d", c), 64'(rsp0_valid), 64'(0));
            step();
        end
        #1;
        chk("mid_idle", 64'(idle), 64'(1));
        chk("mid_count0", 64'(u_dut.count0), 64'(0));
        chk("mid_count1", 64'(u_dut.count1), 64'(0));

        // FIFO alone: push+pop when full, then push+pop when empty.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            f_push = 1'b1;
            f_din = 8'(i);
            step();
        end
        f_push = 1'b0;
        #1;
        chk("fifo_full_count", 64'(f_count), 64'(4));
        f_push = 1'b1;
        f_din = 8'd5;
        f_pop = 1'b1;
        #1;
        chk("fifo_full_head", 64'(f_dout), 64'(1));
        step();
        f_push = 1'b0;
        f_pop = 1'b0;
        #1;
        chk("fifo_full_pushpop_count", 64'(f_count), 64'(4));
        f_pop = 1'b1;
        for (int e = 2; e <= 5; e++) begin
            #1;
            chk($sformatf("fifo_drain_%0d", e), 64'(f_dout), 64'(e));
            step();
        end
        #1;
        chk("fifo_empty_count", 64'(f_count), 64'(0));
        f_push = 1'b1;
        f_din = 8'd9;
        step();
        f_push = 1'b0;
        f_pop = 1'b0;
        #1;
        chk("fifo_empty_pushpop_count", 64'(f_count), 64'(1));
        chk("fifo_empty_pushpop_data", 64'(f_dout), 64'(9));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
